// File: rtl/servo_capture.sv
// servo_capture: measures the high time of a servo-style pulse in prescaled
// ticks and reports it as an 8-bit position on the peripheral bus.
module servo_capture #(
    parameter logic [7:0]  SERVO_CAPTURE_ADDRESS = 8'h00,
    parameter int unsigned PRESCALE              = 95,
    parameter int unsigned MIN_TICKS             = 110,
    parameter int unsigned TIMEOUT_TICKS         = 3405
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic       servo_in
);

    localparam int unsigned  PW           = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST     = PW'(PRESCALE - 1);
    localparam logic [11:0]  TO_TICKS     = 12'(TIMEOUT_TICKS);
    localparam logic [11:0]  MIN_W        = 12'(MIN_TICKS);
    localparam logic [11:0]  MAX_W        = 12'(MIN_TICKS + 255);
    localparam logic [7:0]   ADDR_VALUE   = SERVO_CAPTURE_ADDRESS;
    localparam logic [7:0]   ADDR_STATUS  = SERVO_CAPTURE_ADDRESS + 8'd1;
    localparam logic [7:0]   ADDR_CONTROL = SERVO_CAPTURE_ADDRESS + 8'd2;

    typedef enum logic [1:0] {
        DISARMED,
        ARM,
        WAIT_RISE,
        MEASURE
    } state_t;

    state_t        state, state_n;
    logic          sync1, sync_s, sync_d;
    logic          rise, fall;
    logic          en;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic [11:0]   width, width_n, gap, gap_n;
    logic [7:0]    value;
    logic          st_new, st_under, st_over, st_timeout;
    logic          set_new, set_under, set_over, set_timeout, latch;
    logic [7:0]    res_val;
    logic          res_under, res_over;
    logic          clr_status;
    logic [7:0]    status_word;

    assign rise = sync_s & ~sync_d;
    assign fall = ~sync_s & sync_d;
    assign tick = en && (prescaler == PS_LAST);

    assign clr_status  = (r_en && (address == ADDR_STATUS)) ||
                         (w_en && (address == ADDR_CONTROL) && din[1]);
    assign status_word = {3'b000, sync_s, st_timeout, st_over, st_under, st_new};

    // Two-stage synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync_s <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= servo_in;
            sync_s <= sync1;
            sync_d <= sync_s;
        end
    end

    // Free-running tick prescaler, parked at zero while disabled
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Map the measured width onto the 0..255 position range
    always_comb begin
        res_val   = '0;
        res_under = 1'b0;
        res_over  = 1'b0;
        if (width < MIN_W) begin
            res_under = 1'b1;
        end else if (width > MAX_W) begin
            res_val  = '1;
            res_over = 1'b1;
        end else begin
            res_val = 8'(width - MIN_W);
        end
    end

    // Next-state, counter updates and status events
    always_comb begin
        state_n     = state;
        width_n     = width;
        gap_n       = gap;
        set_new     = 1'b0;
        set_under   = 1'b0;
        set_over    = 1'b0;
        set_timeout = 1'b0;
        latch       = 1'b0;
        if (!en) begin
            state_n = DISARMED;
            width_n = '0;
            gap_n   = '0;
        end else begin
            case (state)
                DISARMED: state_n = ARM;
                ARM: begin
                    if (!sync_s) begin
                        state_n = WAIT_RISE;
                        gap_n   = '0;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        width_n = '0;
                        gap_n   = '0;
                        state_n = MEASURE;
                    end else if (gap == TO_TICKS) begin
                        set_timeout = 1'b1;
                        gap_n       = '0;
                    end else if (tick) begin
                        gap_n = gap + 12'd1;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        latch     = 1'b1;
                        set_new   = 1'b1;
                        set_under = res_under;
                        set_over  = res_over;
                        gap_n     = '0;
                        state_n   = WAIT_RISE;
                    end else if (width == TO_TICKS) begin
                        set_timeout = 1'b1;
                        state_n     = ARM;
                    end else if (tick) begin
                        width_n = width + 12'd1;
                    end
                end
                default: state_n = DISARMED;
            endcase
        end
    end

    // FSM state and width/gap counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DISARMED;
            width <= '0;
            gap   <= '0;
        end else begin
            state <= state_n;
            width <= width_n;
            gap   <= gap_n;
        end
    end

    // Latched position result
    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (latch) begin
            value <= res_val;
        end
    end

    // Sticky status bits: a set event on the clearing cycle wins
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_new     <= 1'b0;
            st_under   <= 1'b0;
            st_over    <= 1'b0;
            st_timeout <= 1'b0;
        end else begin
            st_new     <= (st_new     & ~clr_status) | set_new;
            st_under   <= (st_under   & ~clr_status) | set_under;
            st_over    <= (st_over    & ~clr_status) | set_over;
            st_timeout <= (st_timeout & ~clr_status) | set_timeout;
        end
    end

    // CONTROL enable bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            en <= 1'b0;
        end else if (w_en && (address == ADDR_CONTROL)) begin
            en <= din[0];
        end
    end

    // Registered read data; unmapped addresses force zero every cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout <= '0;
        end else begin
            case (address)
                ADDR_VALUE:   if (r_en) dout <= value;
                ADDR_STATUS:  if (r_en) dout <= status_word;
                ADDR_CONTROL: if (r_en) dout <= {7'b0000000, en};
                default:      dout <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_capture.sv
// Self-checking bench for servo_capture with a shortened timebase.
module tb_servo_capture;

    localparam logic [7:0] BASE = 8'h40;
    localparam int P   = 4;
    localparam int MIN = 110;
    localparam int TO  = 500;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    logic       servo_in;

    int n_checks = 0;
    int n_fail   = 0;

    servo_capture #(
        .SERVO_CAPTURE_ADDRESS(BASE),
        .PRESCALE(P),
        .MIN_TICKS(MIN),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .address(address),
        .w_en(w_en),
        .r_en(r_en),
        .dout(dout),
        .servo_in(servo_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] exp;
        string      name;
    } vec_t;

    task automatic check(input string name, input bit ok,
                         input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One bus cycle: strobes driven on a negedge, dout sampled on the next
    task automatic bus(input logic [7:0] a, input logic wr, input logic rd,
                       input logic [7:0] d, output logic [7:0] q);
        @(negedge clk);
        address = a;
        w_en    = wr;
        r_en    = rd;
        din     = d;
        @(negedge clk);
        w_en    = 1'b0;
        r_en    = 1'b0;
        q       = dout;
        address = BASE;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] q);
        bus(a, 1'b0, 1'b1, 8'h00, q);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus(a, 1'b1, 1'b0, d, q);
    endtask

    // High pulse of exactly ticks*P clocks, followed by a settling period
    task automatic pulse(input int ticks);
        @(negedge clk);
        servo_in = 1'b1;
        repeat (ticks * P) @(negedge clk);
        servo_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Reference: {VALUE, STATUS} produced by a pulse measured as w ticks
    function automatic logic [15:0] model(input int w);
        if (w < MIN)            return {8'h00, 8'h03};
        else if (w > MIN + 255) return {8'hff, 8'h05};
        else                    return {8'(w - MIN), 8'h01};
    endfunction

    // Measured width is n or n-1 ticks depending on prescaler phase
    task automatic check_pulse(input string name, input int n);
        logic [7:0]  v, s;
        logic [15:0] got;
        rd(BASE, v);
        rd(BASE + 8'd1, s);
        got = {v, s};
        check(name, (got == model(n)) || (got == model(n - 1)), got, model(n));
    endtask

    initial begin
        vec_t       vecs[12];
        logic [7:0] q;
        logic [7:0] ua;
        int         n;

        vecs[0]  = '{BASE,        1'b0, 8'h00, 8'h00, "rst_value"};
        vecs[1]  = '{BASE + 8'd1, 1'b0, 8'h00, 8'h00, "rst_status"};
        vecs[2]  = '{BASE + 8'd2, 1'b0, 8'h00, 8'h00, "rst_control"};
        vecs[3]  = '{BASE + 8'd7, 1'b0, 8'h00, 8'h00, "unmapped_rd"};
        vecs[4]  = '{BASE,        1'b1, 8'hff, 8'h00, "wr_value"};
        vecs[5]  = '{BASE + 8'd1, 1'b1, 8'hff, 8'h00, "wr_status"};
        vecs[6]  = '{BASE,        1'b0, 8'h00, 8'h00, "value_ro"};
        vecs[7]  = '{BASE + 8'd1, 1'b0, 8'h00, 8'h00, "status_ro"};
        vecs[8]  = '{BASE + 8'd2, 1'b1, 8'hff, 8'h00, "wr_ctrl_ff"};
        vecs[9]  = '{BASE + 8'd2, 1'b0, 8'h00, 8'h01, "ctrl_masked"};
        vecs[10] = '{BASE + 8'd2, 1'b1, 8'h00, 8'h00, "wr_ctrl_0"};
        vecs[11] = '{BASE + 8'd2, 1'b0, 8'h00, 8'h00, "ctrl_off"};

        rst      = 1'b0;
        din      = '0;
        address  = BASE;
        w_en     = 1'b0;
        r_en     = 1'b0;
        servo_in = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;

        check("rst_dout", dout == 8'h00, {8'h00, dout}, 16'h0000);

        for (int i = 0; i < 12; i++) begin
            bus(vecs[i].addr, vecs[i].wr, ~vecs[i].wr, vecs[i].wdata, q);
            if (!vecs[i].wr)
                check(vecs[i].name, q == vecs[i].exp, {8'h00, q}, {8'h00, vecs[i].exp});
        end

        // Simultaneous write and read of CONTROL returns the old value
        bus(BASE + 8'd2, 1'b1, 1'b1, 8'h01, q);
        check("ctrl_rw_same", q == 8'h00, {8'h00, q}, 16'h0000);
        rd(BASE + 8'd2, q);
        check("ctrl_en", q == 8'h01, {8'h00, q}, 16'h0001);
        // Unmapped address zeroes dout even without a read strobe
        bus(BASE + 8'd7, 1'b0, 1'b0, 8'h00, q);
        check("unmapped_idle", q == 8'h00, {8'h00, q}, 16'h0000);

        // Nominal mid-range pulse
        repeat (1000) @(negedge clk);
        pulse(238);
        check_pulse("pulse_238", 238);
        rd(BASE + 8'd1, q);
        check("status_cleared", q == 8'h00, {8'h00, q}, 16'h0000);

        pulse(50);
        check_pulse("pulse_under", 50);
        repeat (50) @(negedge clk);
        pulse(400);
        check_pulse("pulse_over", 400);

        // Low-level timeout
        repeat (TO * P + 10) @(negedge clk);
        rd(BASE + 8'd1, q);
        check("gap_timeout", q == 8'h08, {8'h00, q}, 16'h0008);

        // Stuck-high timeout, then recovery on a low level plus full pulse
        @(negedge clk);
        servo_in = 1'b1;
        repeat ((TO + 10) * P) @(negedge clk);
        rd(BASE + 8'd1, q);
        check("high_timeout", q == 8'h18, {8'h00, q}, 16'h0018);
        servo_in = 1'b0;
        repeat (20) @(negedge clk);
        rd(BASE + 8'd1, q);
        check("no_new_after_stuck", q == 8'h00, {8'h00, q}, 16'h0000);
        pulse(200);
        check_pulse("pulse_after_stuck", 200);

        // Enable while the input is already high: that pulse is rejected
        wr(BASE + 8'd2, 8'h00);
        @(negedge clk);
        servo_in = 1'b1;
        repeat (10) @(negedge clk);
        wr(BASE + 8'd2, 8'h01);
        repeat (100 * P) @(negedge clk);
        servo_in = 1'b0;
        repeat (10) @(negedge clk);
        rd(BASE + 8'd1, q);
        check("armed_reject", q == 8'h00, {8'h00, q}, 16'h0000);
        pulse(200);
        check_pulse("pulse_200", 200);

        // One-cycle reset in the middle of a measurement
        @(negedge clk);
        servo_in = 1'b1;
        repeat (50 * P) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        servo_in = 1'b0;
        repeat (10) @(negedge clk);
        rd(BASE + 8'd2, q);
        check("mid_rst_ctrl", q == 8'h00, {8'h00, q}, 16'h0000);
        rd(BASE, q);
        check("mid_rst_value", q == 8'h00, {8'h00, q}, 16'h0000);
        rd(BASE + 8'd1, q);
        check("mid_rst_status", q == 8'h00, {8'h00, q}, 16'h0000);

        // Read-clear of STATUS on the same cycle the fall sets NEW
        wr(BASE + 8'd2, 8'h01);
        repeat (10) @(negedge clk);
        servo_in = 1'b1;
        repeat (150 * P) @(negedge clk);
        servo_in = 1'b0;
        @(negedge clk);
        rd(BASE + 8'd1, q);
        check("race_old_status", q == 8'h00, {8'h00, q}, 16'h0000);
        rd(BASE + 8'd1, q);
        check("race_new_kept", q == 8'h01, {8'h00, q}, 16'h0001);
        rd(BASE, q);
        check("race_value", (q == 8'd40) || (q == 8'd39), {8'h00, q}, 16'd40);

        // Randomised pulse widths and unmapped reads
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(5, 200)) @(negedge clk);
            n = int'($urandom_range(20, 450));
            pulse(n);
            check_pulse($sformatf("rand_pulse_%0d_w%0d", i, n), n);
            ua = 8'($urandom_range(32'h43, 32'h13f));
            rd(ua, q);
            check($sformatf("rand_unmapped_%h", ua), q == 8'h00, {8'h00, q}, 16'h0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
